// File: rtl/delay_out_fifo.sv
// -----------------------------------------------------------------------------
// delay_out_fifo
// Small FIFO that sits behind an upstream fixed-latency delay line. A warm-up
// counter follows the same 'en' strobe as the delay line. Once CYCLES enabled
// cycles have elapsed, the delay output holds valid samples. From then on,
// every enabled cycle pushes in_data into a circular buffer.
//
// Ports
//   clk        sole clock, all state on the rising edge
//   rst        synchronous active-low reset
//   en         advance strobe (shared with the upstream delay line)
//   in_data    upstream delay output, captured on push
//   out_valid  head entry available (count != 0)
//   out_ready  consumer accepts the head entry
//   out_data   head entry, registered; holds its last value when empty
//   count      current occupancy, 0..DEPTH
//   full       count == DEPTH
//   warm       warm-up complete
//   overflow   sticky: a push was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module delay_out_fifo #(
    parameter int WIDTH  = 8,
    parameter int CYCLES = 30,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       warm,
    output logic                       overflow
);

    localparam int WW = $clog2(CYCLES + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WW-1:0]    wcnt_q,   wcnt_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             ovf_q,    ovf_d;
    logic [WIDTH-1:0] head_q,   head_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic warm_s;
    logic full_s;
    logic push_req_s;
    logic pop_s;
    logic push_s;
    logic drop_s;

    // Next-state logic for the warm-up counter, pointers, occupancy and head register
    always_comb begin
        warm_s     = (wcnt_q == WW'(CYCLES));
        full_s     = (count_q == CW'(DEPTH));
        // Push uses the registered warm flag, so the first push lands on the
        // enabled cycle after the counter saturates.
        push_req_s = en && warm_s;
        pop_s      = (count_q != {CW{1'b0}}) && out_ready;
        // A full FIFO still accepts a push when a pop frees a slot on the same edge.
        push_s     = push_req_s && (!full_s || pop_s);
        drop_s     = push_req_s && full_s && !pop_s;

        if (en && !warm_s) begin
            wcnt_d = wcnt_q + WW'(1);
        end else begin
            wcnt_d = wcnt_q;
        end

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        ovf_d = ovf_q | drop_s;

        // The head register tracks the entry at the next read pointer. When that
        // slot is being written on this same edge, the memory still holds stale
        // data, so take in_data directly.
        if (count_d == {CW{1'b0}}) begin
            head_d = head_q;
        end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
            head_d = in_data;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            wcnt_q   <= {WW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            ovf_q    <= 1'b0;
            head_q   <= {WIDTH{1'b0}};
        end else begin
            wcnt_q   <= wcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            head_q   <= head_d;
        end
    end

    // Storage array; entries are only meaningful below count, so no reset needed
    always_ff @(posedge clk) begin
        if (rst && push_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_valid = (count_q != {CW{1'b0}});
    assign out_data  = head_q;
    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));
    assign warm      = (wcnt_q == WW'(CYCLES));
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_delay_out_fifo.sv
module tb_delay_out_fifo;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] count;
    logic       full;
    logic       warm;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    // scoreboard model state (post-edge view)
    int         m_wcnt = 0;
    int         m_cnt  = 0;
    bit         m_ovf  = 1'b0;
    bit         m_preq;
    bit         m_pop;
    logic [7:0] sbq[$];
    logic [7:0] exp_d;

    delay_out_fifo #(.WIDTH(8), .CYCLES(30), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .warm      (warm),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: expected pushes go into the scoreboard queue
    always @(posedge clk) begin
        if (!rst) begin
            m_wcnt = 0;
            m_cnt  = 0;
            m_ovf  = 1'b0;
            sbq.delete();
        end else begin
            m_preq = en && (m_wcnt == 30);
            m_pop  = (m_cnt != 0) && out_ready;
            if (m_pop) m_cnt--;
            if (m_preq) begin
                if (m_cnt < 4) begin
                    sbq.push_back(in_data);
                    m_cnt++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (en && m_wcnt < 30) m_wcnt++;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT hands over an entry
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check("pop_nonempty", 32'd0, 32'd1);
            end else begin
                exp_d = sbq.pop_front();
                check("sb_data", out_data, exp_d);
            end
        end
        check("sb_count", count, m_cnt);
        check("sb_valid", out_valid, m_cnt != 0);
        check("sb_full", full, m_cnt == 4);
        check("sb_warm", warm, m_wcnt == 30);
        check("sb_overflow", overflow, m_ovf);
    end

    initial begin
        rst       = 1'b0;
        en        = 1'b0;
        out_ready = 1'b0;
        in_data   = 8'h00;
        step();
        step();
        check("rst_count", count, 3'd0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_warm", warm, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_data", out_data, 8'h00);

        // warm-up with en constantly high
        rst       = 1'b1;
        en        = 1'b1;
        out_ready = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            in_data = 8'(k);
            step();
            if (k == 29) check("warm_e29", warm, 1'b0);
            if (k == 30) begin
                check("warm_e30", warm, 1'b1);
                check("valid_e30", out_valid, 1'b0);
            end
            if (k == 31) begin
                check("valid_e31", out_valid, 1'b1);
                check("data_e31", out_data, 8'h1F);
                check("count_e31", count, 3'd1);
            end
        end
        en = 1'b0;
        step();
        check("drain_e32", count, 3'd0);

        // gated en: 30 enabled edges to warm up, nothing pushed on en=0
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 60; i++) begin
            en = (i % 2 == 0);
            in_data = 8'hC0;
            step();
            if (i == 57) check("gated_warm_29", warm, 1'b0);
            if (i == 58) check("gated_warm_30", warm, 1'b1);
            if (i == 59) check("gated_nopush", count, 3'd0);
        end

        // backpressure, full push+pop, then overflow
        out_ready = 1'b0;
        en        = 1'b1;
        in_data = 8'h11; step();
        in_data = 8'h22; step();
        in_data = 8'h33; step();
        in_data = 8'h44; step();
        check("bp_full", full, 1'b1);
        check("bp_count", count, 3'd4);
        check("bp_head", out_data, 8'h11);
        in_data = 8'h66; out_ready = 1'b1; step();
        check("fpp_count", count, 3'd4);
        check("fpp_ovf", overflow, 1'b0);
        check("fpp_head", out_data, 8'h22);
        in_data = 8'h55; out_ready = 1'b0; step();
        check("drop_ovf", overflow, 1'b1);
        check("drop_count", count, 3'd4);
        check("drop_head", out_data, 8'h22);
        en = 1'b0; out_ready = 1'b1;
        step(); check("drain_33", out_data, 8'h33);
        step(); check("drain_44", out_data, 8'h44);
        step(); check("drain_66", out_data, 8'h66);
        step();
        check("drain_empty", out_valid, 1'b0);
        check("drain_hold", out_data, 8'h66);
        check("ovf_sticky", overflow, 1'b1);

        // mid-run reset with three entries stored
        out_ready = 1'b0;
        en        = 1'b1;
        in_data = 8'hA1; step();
        in_data = 8'hA2; step();
        in_data = 8'hA3; step();
        check("mr_count3", count, 3'd3);
        rst = 1'b0;
        step();
        check("mr_count", count, 3'd0);
        check("mr_valid", out_valid, 1'b0);
        check("mr_warm", warm, 1'b0);
        check("mr_ovf", overflow, 1'b0);
        rst       = 1'b1;
        out_ready = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            in_data = 8'hB0 + 8'(k % 8);
            step();
            if (k == 30) check("mr_nopush30", count, 3'd0);
            if (k == 31) begin
                check("mr_push31", count, 3'd1);
                check("mr_data31", out_data, 8'hB7);
            end
        end

        // random traffic, wrap-around checked by the scoreboard
        for (int i = 0; i < 1000; i++) begin
            en        = ($urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 1) == 1;
            in_data   = 8'($urandom);
            step();
        end
        en        = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("final_empty", count, 3'd0);
        check("final_sb_empty", sbq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/delay_out_fifo.md
DELAY_OUT_FIFO -- requirements
Module: delay_out_fifo

Interface
REQ-001 Parameter: WIDTH, 8, data width of delay output and stream.
REQ-002 Parameter: CYCLES, 30, latency of upstream delay line; warm-up length in enabled cycles; >=1.
REQ-003 Parameter: DEPTH, 4, FIFO entries; power of two, >=2.
REQ-004 Port: clk  input  1  sole clock; all state on rising edge.
REQ-005 Port: rst  input  1  reset; synchronous, active-low.
REQ-006 Port: en  input  1  advance strobe, same signal driving upstream delay en.
REQ-007 Port: in_data  input  WIDTH  upstream delay output, sampled on push.
REQ-008 Port: out_valid  output  1  head entry available.
REQ-009 Port: out_ready  input  1  consumer accepts head.
REQ-010 Port: out_data  output  WIDTH  head entry; undefined-free (holds last value) when out_valid=0.
REQ-011 Port: count  output  $clog2(DEPTH+1)  current occupancy.
REQ-012 Port: full  output  1  count==DEPTH.
REQ-013 Port: warm  output  1  warm-up complete.
REQ-014 Port: overflow  output  1  sticky flag, push dropped.

Function
REQ-015 Warm-up counter wcnt, 0..CYCLES: increments on en when wcnt<CYCLES; saturates at CYCLES; warm = (wcnt==CYCLES).
REQ-016 Push condition: en && warm (registered warm, pre-increment value); first push on the (CYCLES+1)th en cycle after reset, capturing first valid delayed sample.
REQ-017 en=0 cycles: no push, wcnt unchanged.
REQ-018 Pop condition: out_valid && out_ready; out_ready ignored when out_valid=0.
REQ-019 Storage: circular buffer, wr_ptr/rd_ptr modulo DEPTH, wrap from DEPTH-1 to 0 without gap.
REQ-020 Push latency: entry written at edge N presents out_valid=1 and out_data in cycle after edge N (one-cycle latency, no fall-through).
REQ-021 out_valid = (count!=0); out_data = entry at rd_ptr, registered or array-read, stable while out_valid && !out_ready.
REQ-022 Order: strict FIFO; no reorder, no duplication.
REQ-023 Simultaneous push+pop, 0<count<DEPTH: both occur, count unchanged.
REQ-024 Simultaneous push+pop when full: both occur, no drop, overflow not set, count stays DEPTH.
REQ-025 Push when empty with out_ready=1: push only (no same-cycle pop), count becomes 1.
REQ-026 Push when full with no pop: data discarded, pointers/count unchanged, overflow set to 1.
REQ-027 overflow: cleared only by reset.
REQ-028 count increments/decrements by exactly 1 per edge, never exceeds DEPTH, never underflows.

Reset
REQ-029 rst=0 at rising edge: wcnt=0, wr_ptr=0, rd_ptr=0, count=0, out_valid=0, full=0, warm=0, overflow=0, out_data=0.
REQ-030 Reset mid-operation: stored entries discarded; warm-up restarts from 0 irrespective of en.
REQ-031 Reset overrides push/pop in the same cycle.
REQ-032 No output asserts on asynchronous rst edge; effect only at next clk rising edge.

Verification
REQ-033 Warm-up: CYCLES=30, en=1 constant, out_ready=1 -> warm rises after edge 30, first push edge 31, out_valid first high cycle after edge 31, out_data = in_data sampled edge 31.
REQ-034 Gated en: en toggling 1/0 -> warm after exactly 30 en=1 edges; no push on en=0 cycles; wcnt frozen.
REQ-035 Backpressure: DEPTH=4, out_ready=0, in_data 0x11,0x22,0x33,0x44,0x55 on five push cycles -> full=1 after 4th, 0x55 dropped, overflow=1; then out_ready=1 -> out_data 0x11,0x22,0x33,0x44, then out_valid=0.
REQ-036 Full push+pop: count=4, push 0x66 with out_ready=1 -> 0x11 popped, 0x66 stored, count=4, overflow stays 0.
REQ-037 Wrap-around: 1000 random pushes, random out_ready (50%) -> output sequence equals pushed sequence minus dropped entries; count matches scoreboard each cycle.
REQ-038 Mid-run reset: rst=0 for one edge with count=3 -> next cycle count=0, out_valid=0, warm=0, overflow=0; next push only after 31 further en cycles.
